// File: rtl/sample_unpacker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sample_unpacker_pkg
//  Description : Shared helpers for packed-stream blocks: clog2, lane count
//                derivation and word/sample width legality.
//  Revision    : 1.0 - initial release
// ============================================================================
package sample_unpacker_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    function automatic int lanes_of(input int word_width, input int sample_width);
        return (sample_width > 0) ? (word_width / sample_width) : 0;
    endfunction

    // A packed word must hold a whole number of samples, and at least two of them.
    function automatic bit widths_legal(input int word_width, input int sample_width);
        return (sample_width > 0) &&
               ((word_width % sample_width) == 0) &&
               ((word_width / sample_width) >= 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : sample_unpacker
//  Description : Buffers one packed word and emits its signed sample lanes one
//                per cycle over valid/ready, with no bubbles between words.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_unpacker
    import sample_unpacker_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 8,
    parameter int MSB_FIRST    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WORD_WIDTH-1:0]   in_word,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [SAMPLE_WIDTH-1:0] out_sample,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int LANES = lanes_of(WORD_WIDTH, SAMPLE_WIDTH);
    // Guarded so an illegal configuration reaches the elaboration error below
    // instead of tripping over a zero-width counter first.
    localparam int IDX_W = (LANES < 2) ? 1 : clog2(LANES);
    localparam logic [IDX_W-1:0] C_FINAL_IDX = IDX_W'(LANES - 1);

    generate
        if (!widths_legal(WORD_WIDTH, SAMPLE_WIDTH)) begin : g_width_check
            $error("sample_unpacker: WORD_WIDTH must be a multiple of SAMPLE_WIDTH with at least two lanes");
        end
    endgenerate

    logic [WORD_WIDTH-1:0]   r_word;
    logic                    r_last;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_full;

    logic                    w_pop;
    logic                    w_push;
    logic                    w_final;
    logic [IDX_W-1:0]        w_lane;
    logic [SAMPLE_WIDTH-1:0] w_sample;

    assign w_final  = (r_idx == C_FINAL_IDX);
    assign w_pop    = r_full & out_ready;
    // Combinational ready lets the next word load on the final-lane pop.
    assign in_ready = ~r_full | (w_pop & w_final);
    assign w_push   = in_valid & in_ready;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_lane = C_FINAL_IDX - r_idx;
        end else begin : g_lsb_first
            assign w_lane = r_idx;
        end
    endgenerate

    always_comb begin
        w_sample = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_lane == IDX_W'(i)) begin
                w_sample = r_word[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_last <= 1'b0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (w_push) begin
            r_word <= in_word;
            r_last <= in_last;
            r_idx  <= '0;
            r_full <= 1'b1;
        end else if (w_pop) begin
            if (w_final) begin
                r_full <= 1'b0;
                r_idx  <= '0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    // Raw lane bits pass through untouched; the downstream extender owns the sign.
    assign out_sample = w_sample;
    assign out_valid  = r_full;
    assign out_last   = r_full & r_last & w_final;

endmodule
`default_nettype wire

// File: tb/tb_sample_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_unpacker
//  Description : Directed and randomised handshake checks for sample_unpacker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_word;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_sample;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    logic        in_ready_m;
    logic [7:0]  out_sample_m;
    logic        out_last_m;
    logic        out_valid_m;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    sample_unpacker #(.WORD_WIDTH(32), .SAMPLE_WIDTH(8), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .out_sample(out_sample),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    sample_unpacker #(.WORD_WIDTH(32), .SAMPLE_WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .in_word(in_word), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready_m), .out_sample(out_sample_m),
        .out_last(out_last_m), .out_valid(out_valid_m), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sx16(input logic [7:0] s);
        return {{8{s[7]}}, s};
    endfunction

    logic [7:0]  exp_l [4] = '{8'h01, 8'h7F, 8'hFF, 8'h80};
    logic [7:0]  exp_m [4] = '{8'h80, 8'hFF, 8'h7F, 8'h01};
    logic [15:0] exp_x [4] = '{16'h0001, 16'h007F, 16'hFFFF, 16'hFF80};

    logic [8:0] sb[$];
    logic [8:0] ent;
    logic       accepted;
    logic       stalled;
    logic [7:0] held;
    logic       held_last;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_word = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_out_last",   out_last,   0);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_in_ready",   in_ready,   1);

        // Single word, both lane orders, plus the 8->16 extension of each sample
        in_word = 32'h80FF7F01; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("w1_valid",      out_valid,          1);
            chk("w1_sample",     out_sample,         exp_l[k]);
            chk("w1_extended",   sx16(out_sample),   exp_x[k]);
            chk("w1_last",       out_last,           0);
            chk("msb_valid",     out_valid_m,        1);
            chk("msb_sample",    out_sample_m,       exp_m[k]);
            chk("msb_in_ready",  in_ready_m,         (k == 3) ? 1 : 0);
            @(negedge clk);
        end
        #1;
        chk("w1_drained",  out_valid, 0);
        chk("w1_in_ready", in_ready,  1);

        // Back-to-back words, second one ends the frame
        in_word = 32'h04030201; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_word = 32'h08070605; in_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("b2b_valid",  out_valid,  1);
            chk("b2b_sample", out_sample, i + 1);
            chk("b2b_last",   out_last,   (i == 7) ? 1 : 0);
            if (i == 0) chk("b2b_ready_busy",  in_ready, 0);
            if (i == 3) chk("b2b_ready_final", in_ready, 1);
            @(negedge clk);
            if (i == 3) in_valid = 1'b0;
        end
        #1;
        chk("b2b_drained", out_valid, 0);

        // Stall three cycles on lane 2, with an ignored offer upstream
        in_word = 32'h80FF7F01; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1; chk("st_lane0", out_sample, 8'h01);
        @(negedge clk);
        #1; chk("st_lane1", out_sample, 8'h7F);
        @(negedge clk);
        #1; chk("st_lane2", out_sample, 8'hFF);
        out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h11111111;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            #1;
            chk("st_hold_sample", out_sample, 8'hFF);
            chk("st_hold_valid",  out_valid,  1);
            chk("st_in_ready",    in_ready,   0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("st_resume",      out_sample, 8'h80);
        chk("st_resume_last", out_last,   0);
        @(negedge clk);
        #1;
        chk("st_drained", out_valid, 0);

        // Reset after lane 1 has popped discards the rest of the word
        in_word = 32'h44332211; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1; chk("mr_lane0", out_sample, 8'h11);
        @(negedge clk);
        #1; chk("mr_lane1", out_sample, 8'h22);
        @(negedge clk);
        #1; chk("mr_lane2", out_sample, 8'h33);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mr_valid",    out_valid,  0);
        chk("mr_in_ready", in_ready,   1);
        chk("mr_last",     out_last,   0);
        chk("mr_sample",   out_sample, 0);
        rst = 1'b0; in_word = 32'h00000002; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mr_new_valid",  out_valid,  1);
        chk("mr_new_sample", out_sample, 8'h02);
        repeat (4) @(negedge clk);
        #1;
        chk("mr_new_drained", out_valid, 0);

        // Random handshake traffic against a lane-order scoreboard
        accepted = 1'b1; stalled = 1'b0; held = '0; held_last = 1'b0;
        for (int c = 0; c < 3010; c++) begin
            @(negedge clk);
            if (c < 3000) begin
                if (!in_valid || accepted) begin
                    in_valid = ($urandom_range(0, 9) < 7);
                    in_word  = $urandom;
                    in_last  = $urandom_range(0, 1);
                end
                out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (stalled) begin
                chk("rnd_stall_sample", out_sample, held);
                chk("rnd_stall_last",   out_last,   held_last);
                chk("rnd_stall_valid",  out_valid,  1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_unexpected_pop", 1, 0);
                end else begin
                    ent = sb.pop_front();
                    chk("rnd_sample", out_sample, ent[7:0]);
                    chk("rnd_last",   out_last,   ent[8]);
                end
            end
            accepted = in_valid && in_ready;
            if (accepted) begin
                for (int l = 0; l < 4; l++) begin
                    sb.push_back({in_last && (l == 3), in_word[l*8 +: 8]});
                end
            end
            stalled   = out_valid && !out_ready;
            held      = out_sample;
            held_last = out_last;
        end
        chk("rnd_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
